song_selector: RTL

- Upstream stage of the song-number display. Turns raw push-buttons into a registered one-hot song code for the display decoder and the melody player.
- Debounces four buttons: next, prev, confirm, back.
- Runs a browse/play state machine over 4 songs.
- Drives the 5-bit song code (bit 4 = selection valid, bits 3:0 = one-hot index) plus play handshake signals.

---
 rtl/song_selector_pkg.sv | 29 ++
 rtl/song_selector_key.sv | 60 ++++++
 rtl/song_selector.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/song_selector_pkg.sv
// -----------------------------------------------------------------------------
// song_selector_pkg
// Shared definitions for the song selector and the display decoder:
//   - song selection codes (bit 4 = selection valid, bits 3:0 = one-hot index)
//   - browse/play state encoding
//   - default debounce length (20 ms at 100 MHz)
//   - helper that converts a 2-bit song index into its selection code
// -----------------------------------------------------------------------------
package song_selector_pkg;

    localparam logic [4:0] SONG_NONE = 5'b00000;
    localparam logic [4:0] SONG1     = 5'b10001;
    localparam logic [4:0] SONG2     = 5'b10010;
    localparam logic [4:0] SONG3     = 5'b10100;
    localparam logic [4:0] SONG4     = 5'b11000;

    localparam int DB_CYCLES_DEFAULT = 2_000_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BROWSE = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    function automatic logic [4:0] song_code(input logic [1:0] idx);
        return {1'b1, 4'b0001 << idx};
    endfunction

endpackage

// File: rtl/song_selector_key.sv
// -----------------------------------------------------------------------------
// key_debounce
// Cleans up one raw asynchronous push-button.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   key_in    : raw button level (asynchronous, active-high)
//   key_level : debounced level
//   key_press : one-cycle pulse on each rising edge of key_level
// A level change is accepted only after the synchronised input has differed
// from the debounced level for DB_CYCLES consecutive cycles. The press pulse
// is registered, so it appears one cycle after key_level rises.
// -----------------------------------------------------------------------------
module key_debounce
    import song_selector_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press
);

    localparam int              CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level_prev <= 1'b0;
            key_level  <= 1'b0;
            key_press  <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= key_in;
            sync2      <= sync1;
            level_prev <= key_level;
            key_press  <= key_level & ~level_prev;

            // Any cycle that agrees with the current level restarts the count,
            // so only an unbroken run of DB_CYCLES differing samples flips it.
            if (sync2 == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_level <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/song_selector.sv
// -----------------------------------------------------------------------------
// song_selector
// Turns four raw push-buttons into a registered song selection for the
// display decoder and the melody player.
//   clk, rst     : system clock, asynchronous active-high reset
//   en           : song-mode enable (synchronous level); low forces IDLE
//   btn_next     : raw button, select next song (wraps 4 -> 1)
//   btn_prev     : raw button, select previous song (wraps 1 -> 4)
//   btn_confirm  : raw button, start playing the shown song
//   btn_back     : raw button, stop playing and return to browsing
//   song_done    : one-cycle pulse from the player at end of melody
//   song         : 5-bit selection code, 00000 when nothing is selected
//   play_start   : one-cycle pulse on entry to PLAY
//   playing      : high while in PLAY
// All outputs are registered and reflect the state entered on the same edge.
// -----------------------------------------------------------------------------
module song_selector
    import song_selector_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int NUM_SONGS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       btn_back,
    input  logic       song_done,
    output logic [4:0] song,
    output logic       play_start,
    output logic       playing
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_SONGS - 1);

    logic press_next;
    logic press_prev;
    logic press_confirm;
    logic press_back;

    state_t     state;
    state_t     state_nx;
    logic [1:0] index;
    logic [1:0] index_nx;
    logic [4:0] song_nx;
    logic       play_start_nx;
    logic       playing_nx;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk      (clk),
        .rst      (rst),
        .key_in   (btn_next),
        .key_level(),
        .key_press(press_next)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
        .clk      (clk),
        .rst      (rst),
        .key_in   (btn_prev),
        .key_level(),
        .key_press(press_prev)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_confirm (
        .clk      (clk),
        .rst      (rst),
        .key_in   (btn_confirm),
        .key_level(),
        .key_press(press_confirm)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_back (
        .clk      (clk),
        .rst      (rst),
        .key_in   (btn_back),
        .key_level(),
        .key_press(press_back)
    );

    // State register; outputs are registered alongside the state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            index      <= 2'd0;
            song       <= SONG_NONE;
            play_start <= 1'b0;
            playing    <= 1'b0;
        end else begin
            state      <= state_nx;
            index      <= index_nx;
            song       <= song_nx;
            play_start <= play_start_nx;
            playing    <= playing_nx;
        end
    end

    // Next-state logic; en low overrides every button and song_done.
    always_comb begin
        state_nx = state;
        index_nx = index;
        if (!en) begin
            state_nx = ST_IDLE;
            index_nx = 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_BROWSE;
                    index_nx = 2'd0;
                end
                ST_BROWSE: begin
                    if (press_confirm) begin
                        state_nx = ST_PLAY;
                    end else if (press_next && !press_prev) begin
                        index_nx = (index == LAST_IDX) ? 2'd0 : index + 2'd1;
                    end else if (press_prev && !press_next) begin
                        index_nx = (index == 2'd0) ? LAST_IDX : index - 2'd1;
                    end
                end
                ST_PLAY: begin
                    if (song_done || press_back) begin
                        state_nx = ST_BROWSE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    index_nx = 2'd0;
                end
            endcase
        end
    end

    // Output logic: values the outputs take on the coming edge.
    always_comb begin
        song_nx       = (state_nx == ST_IDLE) ? SONG_NONE : song_code(index_nx);
        playing_nx    = (state_nx == ST_PLAY);
        play_start_nx = (state == ST_BROWSE) && (state_nx == ST_PLAY);
    end

endmodule
